// File: rtl/bsg_dataflow_pkg.sv
// Shared types and helpers for the dataflow (valid/yumi, valid/ready) blocks.
package bsg_dataflow_pkg;

    // Parallel-in serial-out sequencer states.
    typedef enum logic {
        eIdle = 1'b0,
        eSend = 1'b1
    } bsg_piso_state_e;

    // Counter width that stays at least one bit wide for single-element cases.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_dff_en.sv
// Enable-gated register bank with no reset; holds a payload word.
module bsg_dff_en #(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] r_data;

    // Capture the incoming word whenever the enable is asserted.
    // NOTE: payload storage carries no reset; its contents are only observed
    // after a load, so a reset net here would add fanout for no benefit.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            r_data <= data_i;
        end
    end

    assign data_o = r_data;

endmodule

// File: rtl/bsg_piso_yumi.sv
// Wide-word to narrow-chunk serializer: valid/yumi on the input side,
// valid/ready on the output side, full throughput across word boundaries.
module bsg_piso_yumi
    import bsg_dataflow_pkg::*;
#(
    parameter int width_p    = 64,
    parameter int els_p      = 4,
    parameter int hi_to_lo_p = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       yumi_o,
    output logic                       v_o,
    output logic [width_p/els_p-1:0]   data_o,
    input  logic                       ready_i
);

    localparam int chunk_w = width_p / els_p;
    localparam int cnt_w   = safe_clog2(els_p);

    if (els_p < 1 || (width_p % els_p) != 0) begin : g_bad_params
        $error("bsg_piso_yumi: els_p must be >= 1 and divide width_p");
    end

    bsg_piso_state_e    r_state;
    bsg_piso_state_e    w_state_nxt;
    logic [cnt_w-1:0]   r_cnt;
    logic [cnt_w-1:0]   w_cnt_nxt;
    logic [width_p-1:0] w_buf;
    logic               w_last;
    logic               w_fire;
    int                 w_sel;

    // Word buffer loads exactly when the upstream word is consumed.
    bsg_dff_en #(.width_p(width_p)) u_buf (
        .clk_i  (clk_i),
        .en_i   (yumi_o),
        .data_i (data_i),
        .data_o (w_buf)
    );

    // Handshake decode: output valid, last-chunk flag, consume decision.
    always_comb begin
        v_o    = (r_state == eSend);
        w_last = (r_cnt == cnt_w'(els_p - 1));
        w_fire = v_o & ready_i;
        yumi_o = v_i & ~reset_i & ((r_state == eIdle) | (w_fire & w_last));
    end

    // Next-state and next-count; a new word always restarts at chunk 0.
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (yumi_o) begin
            w_state_nxt = eSend;
            w_cnt_nxt   = '0;
        end else if (w_fire && !w_last) begin
            w_cnt_nxt   = r_cnt + cnt_w'(1);
        end else if (w_fire && w_last) begin
            w_state_nxt = eIdle;
            w_cnt_nxt   = '0;
        end
    end

    // State and counter registers; reset drops any partial word at once.
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= eIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Chunk-select mux; ordering chosen by hi_to_lo_p.
    always_comb begin
        w_sel = int'(r_cnt);
        if (hi_to_lo_p != 0) begin
            w_sel = els_p - 1 - int'(r_cnt);
        end
        data_o = w_buf[w_sel*chunk_w +: chunk_w];
    end

    // The chunk counter must never run past the last chunk index.
    a_cnt_range: assert property (@(posedge clk_i) disable iff (reset_i)
                                  int'(r_cnt) <= els_p - 1);

endmodule
